// File: rtl/conf_int_mul_pkg.sv
// conf_int_mul_pkg: shared widths, mode encodings and result-width helper
package conf_int_mul_pkg;
  localparam int DEF_OP_BITWIDTH = 32;
  localparam int DEF_DATA_PATH_BITWIDTH = 32;
  localparam int DEF_APX_BITS = DEF_OP_BITWIDTH / 4;
  localparam logic ACC_SEL_ACCURATE = 1'b1;
  localparam logic ACC_SEL_APPROX = 1'b0;
  function automatic int res_width(input int dp);
    return 2 * dp;
  endfunction
endpackage

// File: rtl/conf_int_mul_core.sv
// conf_int_mul_core: combinational signed multiplier, partial-product rows reduced by a binary adder tree
module conf_int_mul_core
  import conf_int_mul_pkg::*;
#(
  parameter int OP_BITWIDTH = DEF_OP_BITWIDTH,
  parameter int DATA_PATH_BITWIDTH = DEF_DATA_PATH_BITWIDTH,
  parameter int APX_BITS = DEF_APX_BITS
) (
  input  logic [OP_BITWIDTH-1:0] a,
  input  logic [OP_BITWIDTH-1:0] b,
  input  logic sel,
  output logic [res_width(DATA_PATH_BITWIDTH)-1:0] d
);
  localparam int N = DATA_PATH_BITWIDTH;
  localparam int W = res_width(N);
  localparam int P = 1 << $clog2(N);
  logic signed [OP_BITWIDTH-1:0] am, bm;
  logic signed [N-1:0] x, y;
  logic signed [W-1:0] xe;
  logic [W-1:0] node [1:2*P-1];
  assign am = sel == ACC_SEL_ACCURATE ? a : {a[OP_BITWIDTH-1:APX_BITS], {APX_BITS{1'b0}}};
  assign bm = sel == ACC_SEL_ACCURATE ? b : {b[OP_BITWIDTH-1:APX_BITS], {APX_BITS{1'b0}}};
  assign x = N'(am);
  assign y = N'(bm);
  assign xe = W'(x);
  // the multiplier's sign bit carries weight -2^(N-1), so its row is negated
  for (genvar j = 0; j < P; j++) begin : g_pp
    if (j < N - 1) begin : g_pos
      assign node[P+j] = y[j] ? xe << j : '0;
    end else if (j == N - 1) begin : g_neg
      assign node[P+j] = y[j] ? (-xe) << j : '0;
    end else begin : g_pad
      assign node[P+j] = '0;
    end
  end
  for (genvar k = 1; k < P; k++) begin : g_tree
    assign node[k] = node[2*k] + node[2*k+1];
  end
  assign d = node[1];
endmodule

// File: rtl/conf_int_mul_wrapper.sv
// conf_int_mul_wrapper: registers operands and mode, product follows combinationally from the core
module conf_int_mul_wrapper
  import conf_int_mul_pkg::*;
#(
  parameter int OP_BITWIDTH = DEF_OP_BITWIDTH,
  parameter int DATA_PATH_BITWIDTH = DEF_DATA_PATH_BITWIDTH,
  parameter int APX_BITS = DEF_APX_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic [OP_BITWIDTH-1:0] a,
  input  logic [OP_BITWIDTH-1:0] b,
  input  logic acc__sel,
  output logic [res_width(DATA_PATH_BITWIDTH)-1:0] d
);
  logic [OP_BITWIDTH-1:0] a_q, b_q;
  logic sel_q;
  always_ff @(posedge clk) begin
    a_q <= !rst ? '0 : a;
    b_q <= !rst ? '0 : b;
    sel_q <= !rst ? ACC_SEL_ACCURATE : acc__sel;
  end
  conf_int_mul_core #(
    .OP_BITWIDTH(OP_BITWIDTH),
    .DATA_PATH_BITWIDTH(DATA_PATH_BITWIDTH),
    .APX_BITS(APX_BITS)
  ) u_core (
    .a(a_q),
    .b(b_q),
    .sel(sel_q),
    .d(d)
  );
endmodule

// File: tb/tb_conf_int_mul_wrapper.sv
// tb_conf_int_mul_wrapper: directed literal checks plus a product model checked every cycle
module tb_conf_int_mul_wrapper;
  logic clk = 0;
  logic rst = 0;
  logic [31:0] a = 0, b = 0;
  logic acc__sel = 1;
  logic [63:0] d;
  logic [63:0] exp_d = 0;
  logic en = 0;
  int total = 0, bad = 0;

  conf_int_mul_wrapper dut (.clk(clk), .rst(rst), .a(a), .b(b), .acc__sel(acc__sel), .d(d));

  always #5 clk = ~clk;

  function automatic logic [63:0] golden(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [31:0] xm, ym;
    xm = s ? x : x & 32'hFFFF_FF00;
    ym = s ? y : y & 32'hFFFF_FF00;
    return longint'($signed(xm)) * longint'($signed(ym));
  endfunction

  always @(posedge clk) exp_d <= !rst ? 64'd0 : golden(a, b, acc__sel);

  always @(posedge clk) begin
    #1;
    if (en) begin
      total++;
      if (d !== exp_d) begin
        bad++;
        $display("FAIL model: a_in=%h b_in=%h got=%h want=%h", a, b, d, exp_d);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] want);
    total++;
    if (d !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, d, want);
    end
  endtask

  task automatic apply(input logic [31:0] x, input logic [31:0] y, input logic s);
    @(negedge clk);
    a = x;
    b = y;
    acc__sel = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    a = 5;
    b = 7;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("reset", 64'd0);
    end
    en = 1;
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    chk("release", 64'h23);
    apply(32'd3, 32'd4, 1);
    chk("3x4", 64'd12);
    apply(32'hFFFF_FFF9, 32'd6, 1);
    chk("neg7x6", 64'hFFFF_FFFF_FFFF_FFD6);
    apply(32'd0, 32'h7FFF_FFFF, 1);
    chk("zero", 64'd0);
    apply(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1);
    chk("maxmax", 64'h3FFF_FFFF_0000_0001);
    apply(32'h8000_0000, 32'h8000_0000, 1);
    chk("minmin", 64'h4000_0000_0000_0000);
    apply(32'h8000_0000, 32'h7FFF_FFFF, 1);
    chk("minmax", 64'hC000_0000_8000_0000);
    apply(32'h105, 32'h100, 0);
    chk("apx", 64'h1_0000);
    apply(32'h105, 32'h100, 1);
    chk("acc", 64'h1_0500);
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("apx_m1", 64'h1_0000);
    apply(32'hFFFF_FF05, 32'h0000_0203, 0);
    chk("apx_mixed", 64'hFFFF_FFFF_FFFE_0000);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      a = $urandom;
      b = $urandom;
      acc__sel = 1;
      rst = (i != 250);
      @(posedge clk);
      #1;
      if (i == 250) chk("mid_reset", 64'd0);
    end
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
